// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus per-row column shift registers.
// Optional SOBEL_WIN_COORD_EN adds win_x/win_y carrying the window centre coordinate.
module sobel_window_3x3 #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        sof,
  input  logic [7:0]  pix_in,
  output logic [23:0] line0,
  output logic [23:0] line1,
  output logic [23:0] line2,
  output logic        win_valid
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  // Position counters and the effective position of the pixel accepted this cycle
  logic [CW-1:0] col_q, col_d, acc_col;
  logic [RW-1:0] row_q, row_d, acc_row;

  always_comb begin
    acc_col = sof ? '0 : col_q;
    acc_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (clken) begin
      if (acc_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (acc_row == RW'(IMG_H - 1)) ? '0 : acc_row + RW'(1);
      end else begin
        col_d = acc_col + CW'(1);
        row_d = acc_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: A holds row r-1, B holds row r-2; contents are never cleared
  logic [7:0] lb_a_q [IMG_W];
  logic [7:0] lb_b_q [IMG_W];
  logic [7:0] lb_a_rd_q, lb_b_rd_q;

  always_ff @(posedge clk) begin
    if (clken) begin
      lb_a_rd_q       <= lb_a_q[acc_col];
      lb_b_rd_q       <= lb_b_q[acc_col];
      lb_a_q[acc_col] <= pix_in;
      lb_b_q[acc_col] <= lb_a_q[acc_col];
    end
  end

  // Stage 1: registered pixel and position alongside the RAM read data
  logic          s1_vld_q;
  logic [7:0]    s1_pix_q;
  logic [CW-1:0] s1_col_q;
  logic [RW-1:0] s1_row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s1_col_q <= '0;
      s1_row_q <= '0;
    end else begin
      s1_vld_q <= clken;
      if (clken) begin
        s1_pix_q <= pix_in;
        s1_col_q <= acc_col;
        s1_row_q <= acc_row;
      end
    end
  end

  // Stage 2: column shift registers, newest pixel enters at the top byte
  logic [23:0] sr0_q, sr1_q, sr2_q;
  logic        s2_emit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr0_q     <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      s2_emit_q <= 1'b0;
    end else begin
      s2_emit_q <= s1_vld_q && (s1_row_q >= RW'(2)) && (s1_col_q >= CW'(2));
      if (s1_vld_q) begin
        sr0_q <= {lb_b_rd_q, sr0_q[23:8]};
        sr1_q <= {lb_a_rd_q, sr1_q[23:8]};
        sr2_q <= {s1_pix_q, sr2_q[23:8]};
      end
    end
  end

  // Output register: holds the last emitted window
  logic [23:0] line0_q, line1_q, line2_q;
  logic        win_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      line0_q     <= '0;
      line1_q     <= '0;
      line2_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= s2_emit_q;
      if (s2_emit_q) begin
        line0_q <= sr0_q;
        line1_q <= sr1_q;
        line2_q <= sr2_q;
      end
    end
  end

  assign line0     = line0_q;
  assign line1     = line1_q;
  assign line2     = line2_q;
  assign win_valid = win_valid_q;

`ifdef SOBEL_WIN_COORD_EN
  logic [CW-1:0] s2_x_q, win_x_q;
  logic [RW-1:0] s2_y_q, win_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_x_q  <= '0;
      s2_y_q  <= '0;
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      if (s1_vld_q) begin
        s2_x_q <= s1_col_q - CW'(1);
        s2_y_q <= s1_row_q - RW'(1);
      end
      if (s2_emit_q) begin
        win_x_q <= s2_x_q;
        win_y_q <= s2_y_q;
      end
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

endmodule
